// File: rtl/dandy_pkg.sv
// Shared types and constants for the dance sequencer: FSM states, segment bits, frame ROM.
package dandy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int FRAMES = 8;
    localparam int IDX_W  = 3;

    localparam logic [6:0] SEG_A = 7'h01;
    localparam logic [6:0] SEG_B = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_D = 7'h08;
    localparam logic [6:0] SEG_E = 7'h10;
    localparam logic [6:0] SEG_F = 7'h20;
    localparam logic [6:0] SEG_G = 7'h40;

    // Rows are patterns (spin, wave, blink, walk), columns are frames 0..7.
    localparam logic [6:0] FRAME_ROM [4][FRAMES] = '{
        '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h01, 7'h02},
        '{7'h40, 7'h09, 7'h40, 7'h36, 7'h40, 7'h09, 7'h40, 7'h36},
        '{7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00},
        '{7'h06, 7'h30, 7'h06, 7'h30, 7'h0E, 7'h38, 7'h0E, 7'h38}
    };

endpackage

// File: rtl/dandy_prescaler.sv
// Frame-rate prescaler: tick every 2^(speed+MIN_SHIFT) enabled cycles; clr parks the count at 0.
module dandy_prescaler #(
    parameter int PRESCALE_W = 24,
    parameter int MIN_SHIFT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [2:0] speed,
    output logic       tick
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] count;
    logic [PRESCALE_W-1:0] limit;

    assign limit = (ONE << (32'(speed) + MIN_SHIFT)) - ONE;
    // >= rather than == so a speed drop below the current count fires at once.
    assign tick  = en && (count >= limit);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= tick ? '0 : count + ONE;
    end

endmodule

// File: rtl/dandy_dance_sequencer.sv
// Dance animation FSM: steps idx through a ROM pattern, drives segments/dp.
// Optional DANCE_BOUNCE_EN makes idx ping-pong 0..7..0 instead of wrapping.
module dandy_dance_sequencer
    import dandy_pkg::*;
#(
    parameter int PRESCALE_W = 24,
    parameter int MIN_SHIFT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             run,
    input  logic             step,
    input  logic [2:0]       speed,
    input  logic [1:0]       pattern,
    output logic [6:0]       segments,
    output logic             dp,
    output logic [IDX_W-1:0] step_idx,
    output logic             running
);

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             step_q;
    logic             wrap_q;
    logic             tick;
    logic             step_edge;
    logic             adv;
    logic             rev;
`ifdef DANCE_BOUNCE_EN
    logic             dir_up;
`endif

    dandy_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .MIN_SHIFT  (MIN_SHIFT)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (state == RUN && ena),
        .clr   (state == IDLE),
        .speed (speed),
        .tick  (tick)
    );

    assign step_edge = (state == PAUSE) && step && !step_q;
    assign adv       = ena && (tick || step_edge);
    assign step_idx  = idx;

    always_comb begin
        idx_nxt = idx + IDX_ONE;
        rev     = (idx == IDX_W'(FRAMES - 1));
`ifdef DANCE_BOUNCE_EN
        if (dir_up) begin
            rev = (idx == IDX_W'(FRAMES - 2));
        end else begin
            idx_nxt = idx - IDX_ONE;
            rev     = (idx == IDX_ONE);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            running  <= 1'b0;
            idx      <= '0;
            segments <= '0;
            dp       <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef DANCE_BOUNCE_EN
            dir_up   <= 1'b1;
`endif
        end else begin
            step_q   <= step;
            // wrap_q delays dp by one so it lines up with the segments of the new frame.
            wrap_q   <= adv && rev;
            dp       <= wrap_q;
            segments <= (ena && state != IDLE) ? FRAME_ROM[pattern][idx] : '0;
            running  <= ena && run;
            if (adv) begin
                idx <= idx_nxt;
`ifdef DANCE_BOUNCE_EN
                if (rev)
                    dir_up <= !dir_up;
`endif
            end
            case (state)
                IDLE:    if (ena) state <= run ? RUN : PAUSE;
                RUN:     if (!ena) state <= IDLE; else if (!run) state <= PAUSE;
                PAUSE:   if (!ena) state <= IDLE; else if (run) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dandy_dance_sequencer.sv
// Randomized scoreboard bench for dandy_dance_sequencer (MIN_SHIFT=2).
module tb_dandy_dance_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       run = 1'b1;
    logic       step = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [1:0] pattern = 2'd0;
    logic [6:0] segments;
    logic       dp;
    logic [2:0] step_idx;
    logic       running;

    dandy_dance_sequencer #(.PRESCALE_W(24), .MIN_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .run(run), .step(step),
        .speed(speed), .pattern(pattern),
        .segments(segments), .dp(dp), .step_idx(step_idx), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int segs;
        int dp;
        int idx;
        int running;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

`ifdef DANCE_BOUNCE_EN
    localparam int PER = 14;
`else
    localparam int PER = 8;
`endif

    int rom [4][8] = '{
        '{'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h01, 'h02},
        '{'h40, 'h09, 'h40, 'h36, 'h40, 'h09, 'h40, 'h36},
        '{'h7F, 'h00, 'h7F, 'h00, 'h7F, 'h00, 'h7F, 'h00},
        '{'h06, 'h30, 'h06, 'h30, 'h0E, 'h38, 'h0E, 'h38}
    };

    // Model: st 0=idle 1=run 2=pause; ph is the position in the animation cycle.
    int m_st = 0, m_cnt = 0, m_ph = 0, m_stepq = 0, m_pend = 0;
    int m_segs = 0, m_dp = 0, m_run = 0;

    function automatic int frame(input int p);
        return (p < 8) ? p : 14 - p;
    endfunction

    task automatic drive(input bit r, input bit e, input bit ru, input bit s,
                         input int sp, input int pt);
        int lim;
        bit tk, se, adv;
        exp_t x;
        @(negedge clk);
        rst = r; ena = e; run = ru; step = s; speed = 3'(sp); pattern = 2'(pt);
        if (r) begin
            m_st = 0; m_cnt = 0; m_ph = 0; m_stepq = 0; m_pend = 0;
            m_segs = 0; m_dp = 0; m_run = 0;
        end else begin
            lim = (1 << (sp + 2)) - 1;
            tk  = (m_st == 1) && e && (m_cnt >= lim);
            se  = (m_st == 2) && s && (m_stepq == 0);
            adv = e && (tk || se);
            m_segs = (e && m_st != 0) ? rom[pt][frame(m_ph)] : 0;
            m_dp = m_pend;
            m_pend = 0;
            if (adv) begin
                m_ph = (m_ph + 1) % PER;
                m_pend = (PER == 14) ? int'(m_ph == 7 || m_ph == 0) : int'(m_ph == 0);
            end
            if (m_st == 0) m_cnt = 0;
            else if (m_st == 1 && e) m_cnt = tk ? 0 : m_cnt + 1;
            m_st = e ? (ru ? 1 : 2) : 0;
            m_run = (m_st == 1);
            m_stepq = s;
        end
        x.segs = m_segs; x.dp = m_dp; x.idx = frame(m_ph); x.running = m_run;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a new output set, one expectation is consumed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("segments", int'(segments), e.segs);
                chk("dp", int'(dp), e.dp);
                chk("step_idx", int'(step_idx), e.idx);
                chk("running", int'(running), e.running);
            end
        end
    end

    initial begin
        int sp, pt, guard;
        bit r, e, ru, s;
        repeat (3) drive(1, 1, 1, 0, 0, 0);
        repeat (40) drive(0, 1, 1, 0, 0, 0);
        guard = 0;
        while (frame(m_ph) != 3 && guard < 100) begin
            drive(0, 1, 1, 0, 0, 0);
            guard++;
        end
        repeat (20) drive(0, 1, 0, 0, 0, 0);
        repeat (2) begin
            drive(0, 1, 0, 1, 0, 0);
            repeat (3) drive(0, 1, 0, 0, 0, 0);
        end
        repeat (10) drive(0, 1, 0, 1, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        repeat (11) drive(0, 1, 1, 0, 0, 0);
        repeat (2) drive(0, 1, 1, 0, 0, 0);
        repeat (30) drive(0, 1, 1, 0, 2, 0);
        repeat (12) drive(0, 1, 1, 0, 3, 0);
        repeat (8) drive(0, 1, 1, 0, 0, 0);
        repeat (5) drive(0, 0, 1, 0, 0, 0);
        repeat (20) drive(0, 1, 1, 0, 0, 0);
        for (int p = 1; p < 4; p++) repeat (30) drive(0, 1, 1, 0, 0, p);
        drive(1, 1, 1, 0, 0, 1);
        repeat (40) drive(0, 1, 1, 0, 0, 2);
        sp = 0; pt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sp = $urandom_range(0, 2);
            if ($urandom_range(0, 49) == 0) pt = $urandom_range(0, 3);
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 39) != 0);
            ru = ($urandom_range(0, 9) < 7);
            s  = $urandom_range(0, 1);
            drive(r, e, ru, s, sp, pt);
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
